uart_rx_word: RTL and testbench

Serial UART receiver that sits directly upstream of the single-cycle MIPS core's UART write port. It deserialises 8N1 frames from the rx pin and packs four consecutive bytes, little-endian, into one 32-bit word. It presents that word on UART_DATA with a one-cycle W_UART strobe, which the core's data RAM captures into its UART mailbox location.

---
 rtl/uart_rx_word.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_word.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver packing BIT_WIDTH/8 bytes little-endian into one word.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx_word #(
  parameter int BIT_WIDTH    = 32,
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [BIT_WIDTH-1:0] UART_DATA,
  output logic                 W_UART,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int NB = BIT_WIDTH / 8;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic [IW-1:0]          r_idx;
  logic [BIT_WIDTH-1:0]   r_word;
  logic [BIT_WIDTH-1:0]   w_word;

  logic w_rx_s;
  logic w_mid;
  logic w_last;
  logic w_par_bad;
  logic w_data_smp;
  logic w_stop_ok;
  logic w_stop_bad;

  assign w_rx_s = r_sync[SYNC_STAGES-1];
  assign w_mid  = (r_cnt == MID);
  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_rx_s) w_next = S_START;
      S_START: if (w_mid) w_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (w_last && r_bit == 3'd7)
`ifdef UART_RX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_last) w_next = S_STOP;
`endif
      S_STOP:  if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    w_data_smp = (r_state == S_DATA) && w_last;
    w_stop_ok  = (r_state == S_STOP) && w_last && w_rx_s && !w_par_bad;
    w_stop_bad = (r_state == S_STOP) && w_last && !(w_rx_s && !w_par_bad);
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_err;

  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE)
      r_par_err <= 1'b0;
    else if (r_state == S_PARITY && w_last)
      r_par_err <= (w_rx_s != ^r_shift);
  end

  assign w_par_bad = r_par_err;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:  r_cnt <= '0;
        S_START: r_cnt <= w_mid ? '0 : r_cnt + 1'b1;
        default: r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit   <= '0;
      r_shift <= '0;
    end else if (r_state == S_IDLE) begin
      r_bit   <= '0;
    end else if (w_data_smp) begin
      r_bit   <= r_bit + 1'b1;
      r_shift <= {w_rx_s, r_shift[7:1]};
    end
  end

  always_comb begin
    w_word = r_word;
    w_word[{r_idx, 3'b000} +: 8] = r_shift;
  end

  // Partial word is only committed on a clean stop; errors restart at lane 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word    <= '0;
      r_idx     <= '0;
      UART_DATA <= '0;
      W_UART    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      W_UART    <= 1'b0;
      frame_err <= 1'b0;
      if (w_stop_ok) begin
        if (r_idx == IDX_LAST) begin
          UART_DATA <= w_word;
          W_UART    <= 1'b1;
          r_word    <= '0;
          r_idx     <= '0;
        end else begin
          r_word    <= w_word;
          r_idx     <= r_idx + 1'b1;
        end
      end else if (w_stop_bad) begin
        frame_err <= 1'b1;
        r_word    <= '0;
        r_idx     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at CLKS_PER_BIT=8, BIT_WIDTH=32.
// Define UART_RX_PARITY_EN to also exercise the 8E1 parity check.
module tb_uart_rx_word;

  localparam int CPB = 8;
  localparam int BW  = 32;
  localparam int SS  = 2;
`ifdef UART_RX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic [BW-1:0] UART_DATA;
  logic          W_UART;
  logic          frame_err;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_fe  = 0;
  int n_both = 0;
  logic [31:0] wq[$];
  int          cq[$];

  uart_rx_word #(
    .BIT_WIDTH(BW),
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .UART_DATA(UART_DATA),
    .W_UART(W_UART),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (W_UART) begin
      wq.push_back(UART_DATA);
      cq.push_back(cyc);
    end
    if (frame_err) n_fe++;
    if (W_UART && frame_err) n_both++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // good_stop=0 holds the line low across the stop-bit sample point only,
  // so the receiver is back in idle before the next start bit.
  task automatic send(input logic [7:0] d, input logic good_stop,
                      input logic par);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx_in = par;
    tick(CPB);
`else
    if (par === 1'bx) rx_in = 1'b1;
`endif
    if (good_stop) begin
      rx_in = 1'b1;
      tick(CPB);
    end else begin
      rx_in = 1'b0;
      tick(CPB / 2 + 1);
      rx_in = 1'b1;
      tick(CPB / 2 - 1);
    end
  endtask

  task automatic sendb(input logic [7:0] d);
    send(d, 1'b1, ^d);
  endtask

  int w0, f0, b0, hi;
  logic busy_end;

  initial begin
    tick(1);
    tick(2);
    chk("rst_data", UART_DATA, 32'h0);
    chk("rst_wu", {31'b0, W_UART}, 32'h0);
    chk("rst_fe", {31'b0, frame_err}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    tick(3);

    w0 = wq.size(); f0 = n_fe;
    sendb(8'h78); sendb(8'h56); sendb(8'h34); sendb(8'h12);
    tick(20);
    chk("t1_npulse", wq.size() - w0, 1);
    chk("t1_word", wq[wq.size()-1], 32'h12345678);
    chk("t1_hold", UART_DATA, 32'h12345678);
    chk("t1_wu_low", {31'b0, W_UART}, 32'h0);
    chk("t1_nfe", n_fe - f0, 0);

    w0 = wq.size(); f0 = n_fe;
    sendb(8'hEF); sendb(8'hBE);
    send(8'hAD, 1'b0, ^8'hAD);
    sendb(8'hEF); sendb(8'hBE); sendb(8'hAD); sendb(8'hDE);
    tick(20);
    chk("t2_nfe", n_fe - f0, 1);
    chk("t2_npulse", wq.size() - w0, 1);
    chk("t2_word", wq[wq.size()-1], 32'hDEADBEEF);
    chk("t2_hold", UART_DATA, 32'hDEADBEEF);

    w0 = wq.size(); f0 = n_fe; hi = 0;
    rx_in = 1'b0;
    tick(1);
    chk("t3_busy0", {31'b0, busy}, 32'h0);
    tick(1);
    rx_in = 1'b1;
    for (int i = 2; i < 8; i++) begin
      if (busy) hi++;
      tick(1);
    end
    busy_end = busy;
    chk("t3_busy_seen", {31'b0, (hi > 0)}, 32'h1);
    chk("t3_busy_len", {31'b0, (hi <= CPB / 2 + SS)}, 32'h1);
    chk("t3_busy_end", {31'b0, busy_end}, 32'h0);
    tick(2 * CPB);
    chk("t3_nostrobe", (wq.size() - w0) + (n_fe - f0), 0);
    sendb(8'h01); sendb(8'h02); sendb(8'h03); sendb(8'h04);
    tick(20);
    chk("t3_npulse", wq.size() - w0, 1);
    chk("t3_word", wq[wq.size()-1], 32'h04030201);

    w0 = wq.size(); f0 = n_fe;
    sendb(8'h11); sendb(8'h22);
    rx_in = 1'b0;
    tick(CPB);
    rx_in = 1'b1;
    tick(3 * CPB);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t4_data", UART_DATA, 32'h0);
    chk("t4_wu", {31'b0, W_UART}, 32'h0);
    chk("t4_fe", {31'b0, frame_err}, 32'h0);
    chk("t4_busy", {31'b0, busy}, 32'h0);
    tick(3 * CPB);
    sendb(8'hAA); sendb(8'hBB); sendb(8'hCC); sendb(8'hDD);
    tick(20);
    chk("t4_npulse", wq.size() - w0, 1);
    chk("t4_word", wq[wq.size()-1], 32'hDDCCBBAA);
    chk("t4_nfe", n_fe - f0, 0);

    w0 = wq.size(); f0 = n_fe;
    for (int i = 1; i <= 8; i++) sendb(8'(i * 17));
    tick(20);
    chk("t5_npulse", wq.size() - w0, 2);
    if (wq.size() - w0 >= 2) begin
      chk("t5_word0", wq[w0], 32'h44332211);
      chk("t5_word1", wq[w0+1], 32'h88776655);
      chk("t5_gap", cq[w0+1] - cq[w0], 4 * FBITS * CPB);
    end
    chk("t5_nfe", n_fe - f0, 0);

`ifdef UART_RX_PARITY_EN
    w0 = wq.size(); f0 = n_fe;
    send(8'h03, 1'b1, 1'b1);
    tick(10);
    chk("t6_nfe", n_fe - f0, 1);
    send(8'h03, 1'b1, 1'b0);
    sendb(8'h02); sendb(8'h01); sendb(8'h00);
    tick(20);
    chk("t6_npulse", wq.size() - w0, 1);
    chk("t6_word", wq[wq.size()-1], 32'h00010203);
    chk("t6_nfe2", n_fe - f0, 1);
`endif

    chk("no_overlap", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
